e_m_pipe_reg: RTL and testbench
===============================

# e_m_pipe_reg

E/M pipeline register of the five-stage MIPS core. Captures Execute-stage results at each clock edge and presents them to the Memory stage. The captured results are the final destination register chosen by the E-stage RegDst mux, the ALU result, the forwarded store data, PC, instruction and delay-slot flag. It also folds E-stage overflow into the exception code, cancels register writes for excepting instructions, decrements the forwarding Tnew counter, and flushes on interrupt/exception request.

## Interface
- `RESET_PC`, 32'h0000_3000: PC value loaded on reset.
- `HANDLER_PC`, 32'h0000_4180: PC value loaded on flush (`Req`).
- `clk` input 1: single core clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high; one clock; reset is synchronous and active-high.
- `Req` input 1: interrupt/exception request from CP0; flushes the register. Synchronous, same edge as capture.
- `E_PC` input 32: PC of the E-stage instruction.
- `E_Instr` input 32: instruction word.
- `E_BD` input 1: instruction is in a branch delay slot.
- `E_A3` input 5: final destination register from the E-stage RegDst mux; 0 means no write.
- `E_ALUOut` input 32: ALU result or effective address.
- `E_RT` input 32: forwarded rt value, used as store data.
- `E_Tnew` input 2: cycles until the result is available, counted from E.
- `E_ExcCode` input 5: exception code carried from F/D; 0 means none.
- `E_Ov` input 1: ALU 32-bit signed overflow this cycle.
- `E_OvKind` input 2: overflow meaning. 00 ignore, 01 arithmetic (add/sub/addi), 10 load address, 11 store address.
- `M_PC`, `M_Instr`, `M_ALUOut`, `M_RT` output 32: registered copies.
- `M_BD` output 1, `M_A3` output 5, `M_Tnew` output 2, `M_ExcCode` output 5: registered, after the rules below.

## Operation
- Each rising edge has exactly one action; priority is `reset` > `Req` > capture.
- **reset:** `M_PC`=RESET_PC; all other outputs 0.
- **Req:** `M_PC`=HANDLER_PC; all other outputs 0, including `M_BD`=0 and `M_ExcCode`=0. The result is a bubble that writes nothing.
- **capture, exception merge:**
  - If `E_ExcCode`≠0, `M_ExcCode`=`E_ExcCode`, because the earlier stage wins.
  - Else, if `E_Ov`=1, the code depends on `E_OvKind`: 01→12 (Ov), 10→4 (AdEL), 11→5 (AdES), 00→0.
  - Otherwise `M_ExcCode`=0.
- **capture, write cancel:** if the merged `M_ExcCode`≠0, `M_A3`=0. Otherwise `M_A3`=`E_A3`.
- **capture, Tnew:** `M_Tnew` = `E_Tnew`−1 if `E_Tnew`≠0, else 0. It saturates at 0 and never wraps to 3.
- **capture, pass-through:** PC, Instr, BD, ALUOut and RT are copied unchanged.
- No stall input; the E/M register is never stalled. Stalls are inserted at D/E.
- No combinational path from any input to any output.

## Timing
- Latency is 1 cycle. Inputs sampled at edge *n* appear on outputs after edge *n*, until edge *n+1*.
- `Req` asserted together with a valid E instruction: that instruction is discarded and is not captured.
- `Req` and `reset` together: the reset values apply, so `M_PC`=RESET_PC.
- `reset` mid-stream: the very next edge gives reset values regardless of the other inputs. Capture resumes on the first edge with `reset`=0.
- Back-to-back: a new instruction is captured every cycle, with no idle cycles required.

## Test plan
- **Reset:** `reset`=1 for one edge with arbitrary inputs -> `M_PC`=0x3000, and `M_A3`, `M_ExcCode`, `M_Tnew`, `M_ALUOut` all 0.
- **Normal capture:** `E_PC`=0x3004, `E_A3`=8, `E_ALUOut`=0x1234, `E_Tnew`=2, no exception -> next cycle `M_A3`=8, `M_ALUOut`=0x1234, `M_Tnew`=1, `M_ExcCode`=0.
- **Tnew saturation:** `E_Tnew`=0 -> `M_Tnew`=0. Then `E_Tnew`=1 -> `M_Tnew`=0.
- **Overflow:** `E_Ov`=1 with `E_A3`=9.
  - `E_OvKind`=01 -> `M_ExcCode`=12, `M_A3`=0.
  - `E_OvKind`=11 -> `M_ExcCode`=5.
  - `E_OvKind`=00 -> `M_ExcCode`=0, `M_A3`=9.
- **Priority:** `E_ExcCode`=10 (RI) with `E_Ov`=1 and `E_OvKind`=01 -> `M_ExcCode`=10, `M_A3`=0.
- **Flush:**
  - `Req`=1 with `E_PC`=0x3010, `E_A3`=3, `E_BD`=1 -> `M_PC`=0x4180, `M_A3`=0, `M_BD`=0, `M_ExcCode`=0.
  - Next edge with `Req`=0 captures normally.
  - `Req`=1 and `reset`=1 together -> `M_PC`=0x3000.

Source files
------------

// File: rtl/e_m_pipe_reg.sv
// E/M pipeline register of the five-stage MIPS core.
// Captures Execute-stage results on every rising edge and presents them to the
// Memory stage. On the way through it merges E-stage overflow into the
// exception code, cancels the register write of an excepting instruction and
// counts the forwarding Tnew value down by one. A CP0 request (Req) replaces the
// captured instruction with a bubble that restarts at the exception handler.
// There is no stall input: stalls are inserted upstream at D/E.
// There is no handshake: every edge performs exactly one action, with the
// priority reset > Req > capture.
module e_m_pipe_reg #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic [31:0] E_PC,
  input  logic [31:0] E_Instr,
  input  logic        E_BD,
  input  logic [4:0]  E_A3,
  input  logic [31:0] E_ALUOut,
  input  logic [31:0] E_RT,
  input  logic [1:0]  E_Tnew,
  input  logic [4:0]  E_ExcCode,
  input  logic        E_Ov,
  input  logic [1:0]  E_OvKind,
  output logic [31:0] M_PC,
  output logic [31:0] M_Instr,
  output logic        M_BD,
  output logic [4:0]  M_A3,
  output logic [31:0] M_ALUOut,
  output logic [31:0] M_RT,
  output logic [1:0]  M_Tnew,
  output logic [4:0]  M_ExcCode
);

  // Exception codes raised by this stage.
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Overflow interpretations supplied by the E-stage decoder.
  localparam logic [1:0] OV_IGNORE = 2'b00;
  localparam logic [1:0] OV_ARITH  = 2'b01;
  localparam logic [1:0] OV_LOAD   = 2'b10;
  localparam logic [1:0] OV_STORE  = 2'b11;

  logic [4:0] ov_code;
  logic [4:0] cap_exc;
  logic [4:0] cap_a3;
  logic [1:0] cap_tnew;

  // Values a plain capture would load: the exception merge (the earlier stage
  // wins over overflow), the write cancel and the saturating Tnew decrement.
  always_comb begin
    ov_code  = EXC_NONE;
    cap_exc  = EXC_NONE;
    cap_a3   = E_A3;
    cap_tnew = 2'd0;

    case (E_OvKind)
      OV_ARITH:  ov_code = EXC_OV;
      OV_LOAD:   ov_code = EXC_ADEL;
      OV_STORE:  ov_code = EXC_ADES;
      OV_IGNORE: ov_code = EXC_NONE;
      default:   ov_code = EXC_NONE;
    endcase

    if (E_ExcCode != EXC_NONE) begin
      cap_exc = E_ExcCode;
    end else if (E_Ov) begin
      cap_exc = ov_code;
    end

    // An instruction that traps must not update the register file.
    if (cap_exc != EXC_NONE) begin
      cap_a3 = 5'd0;
    end

    // Tnew counts down towards 0 and stays there; it must never wrap to 3.
    if (E_Tnew != 2'd0) begin
      cap_tnew = E_Tnew - 2'd1;
    end
  end

  // Pipeline register: reset, then flush to a handler bubble, then capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      M_PC      <= RESET_PC;
      M_Instr   <= 32'd0;
      M_BD      <= 1'b0;
      M_A3      <= 5'd0;
      M_ALUOut  <= 32'd0;
      M_RT      <= 32'd0;
      M_Tnew    <= 2'd0;
      M_ExcCode <= EXC_NONE;
    end else if (Req) begin
      M_PC      <= HANDLER_PC;
      M_Instr   <= 32'd0;
      M_BD      <= 1'b0;
      M_A3      <= 5'd0;
      M_ALUOut  <= 32'd0;
      M_RT      <= 32'd0;
      M_Tnew    <= 2'd0;
      M_ExcCode <= EXC_NONE;
    end else begin
      M_PC      <= E_PC;
      M_Instr   <= E_Instr;
      M_BD      <= E_BD;
      M_A3      <= cap_a3;
      M_ALUOut  <= E_ALUOut;
      M_RT      <= E_RT;
      M_Tnew    <= cap_tnew;
      M_ExcCode <= cap_exc;
    end
  end

endmodule

// File: tb/tb_e_m_pipe_reg.sv
// Bench for e_m_pipe_reg: a table of directed vectors (inputs plus
// hand-computed expected outputs) applied one per edge, followed by short
// hand-written sequences for output stability and back-to-back capture.
module tb_e_m_pipe_reg;

  logic        clk;
  logic        reset;
  logic        Req;
  logic [31:0] E_PC;
  logic [31:0] E_Instr;
  logic        E_BD;
  logic [4:0]  E_A3;
  logic [31:0] E_ALUOut;
  logic [31:0] E_RT;
  logic [1:0]  E_Tnew;
  logic [4:0]  E_ExcCode;
  logic        E_Ov;
  logic [1:0]  E_OvKind;
  logic [31:0] M_PC;
  logic [31:0] M_Instr;
  logic        M_BD;
  logic [4:0]  M_A3;
  logic [31:0] M_ALUOut;
  logic [31:0] M_RT;
  logic [1:0]  M_Tnew;
  logic [4:0]  M_ExcCode;

  int errors = 0;
  int checks = 0;

  e_m_pipe_reg dut (
    .clk(clk), .reset(reset), .Req(Req),
    .E_PC(E_PC), .E_Instr(E_Instr), .E_BD(E_BD), .E_A3(E_A3),
    .E_ALUOut(E_ALUOut), .E_RT(E_RT), .E_Tnew(E_Tnew),
    .E_ExcCode(E_ExcCode), .E_Ov(E_Ov), .E_OvKind(E_OvKind),
    .M_PC(M_PC), .M_Instr(M_Instr), .M_BD(M_BD), .M_A3(M_A3),
    .M_ALUOut(M_ALUOut), .M_RT(M_RT), .M_Tnew(M_Tnew), .M_ExcCode(M_ExcCode)
  );

  // Clock: 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        req;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        bd;
    logic [4:0]  a3;
    logic [31:0] alu;
    logic [31:0] rt;
    logic [1:0]  tnew;
    logic [4:0]  exc;
    logic        ov;
    logic [1:0]  ovk;
    logic [31:0] x_pc;
    logic [31:0] x_instr;
    logic        x_bd;
    logic [4:0]  x_a3;
    logic [31:0] x_alu;
    logic [31:0] x_rt;
    logic [1:0]  x_tnew;
    logic [4:0]  x_exc;
  } vec_t;

  vec_t vecs[$];

  // Expected-output scoreboard for the back-to-back stream: {pc, a3, tnew, exc}.
  logic [43:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset     = v.rst;
    Req       = v.req;
    E_PC      = v.pc;
    E_Instr   = v.instr;
    E_BD      = v.bd;
    E_A3      = v.a3;
    E_ALUOut  = v.alu;
    E_RT      = v.rt;
    E_Tnew    = v.tnew;
    E_ExcCode = v.exc;
    E_Ov      = v.ov;
    E_OvKind  = v.ovk;
  endtask

  task automatic check_all(input vec_t v);
    check({v.name, ".pc"},    M_PC,              v.x_pc);
    check({v.name, ".instr"}, M_Instr,           v.x_instr);
    check({v.name, ".bd"},    {31'd0, M_BD},     {31'd0, v.x_bd});
    check({v.name, ".a3"},    {27'd0, M_A3},     {27'd0, v.x_a3});
    check({v.name, ".alu"},   M_ALUOut,          v.x_alu);
    check({v.name, ".rt"},    M_RT,              v.x_rt);
    check({v.name, ".tnew"},  {30'd0, M_Tnew},   {30'd0, v.x_tnew});
    check({v.name, ".exc"},   {27'd0, M_ExcCode}, {27'd0, v.x_exc});
  endtask

  // Vector with no exception/overflow; expected outputs are a straight copy
  // with the given expected Tnew.
  function automatic vec_t plain(input string name, input logic [31:0] pc, input logic [4:0] a3,
                                 input logic [31:0] alu, input logic [1:0] tnew, input logic [1:0] x_tnew);
    vec_t v;
    v = '{name: name, rst: 1'b0, req: 1'b0, pc: pc, instr: pc ^ 32'h0123_4567, bd: 1'b0,
          a3: a3, alu: alu, rt: ~alu, tnew: tnew, exc: 5'd0, ov: 1'b0, ovk: 2'b00,
          x_pc: pc, x_instr: pc ^ 32'h0123_4567, x_bd: 1'b0, x_a3: a3, x_alu: alu,
          x_rt: ~alu, x_tnew: x_tnew, x_exc: 5'd0};
    return v;
  endfunction

  function automatic vec_t exc_vec(input string name, input logic [31:0] pc, input logic [4:0] a3,
                                   input logic [4:0] exc, input logic ov, input logic [1:0] ovk,
                                   input logic [4:0] x_a3, input logic [4:0] x_exc);
    vec_t v;
    v = plain(name, pc, a3, 32'h7FFF_FFF0 + pc, 2'd2, 2'd1);
    v.exc = exc;  v.ov = ov;  v.ovk = ovk;
    v.x_a3 = x_a3;  v.x_exc = x_exc;
    return v;
  endfunction

  function automatic vec_t bubble(input string name, input logic rst, input logic req, input logic [31:0] x_pc);
    vec_t v;
    v = plain(name, 32'h0000_3010, 5'd3, 32'hDEAD_BEEF, 2'd3, 2'd0);
    v.rst = rst;  v.req = req;  v.bd = 1'b1;  v.exc = 5'd4;  v.ov = 1'b1;  v.ovk = 2'b01;
    v.x_pc = x_pc;  v.x_instr = 32'd0;  v.x_a3 = 5'd0;  v.x_alu = 32'd0;
    v.x_rt = 32'd0;  v.x_tnew = 2'd0;  v.x_exc = 5'd0;  v.x_bd = 1'b0;
    return v;
  endfunction

  initial begin
    vec_t v;
    logic [43:0] got;
    logic [31:0] pc_s;
    logic [4:0]  a3_s;
    logic [1:0]  tn_s;

    // Directed table.
    vecs.push_back(bubble("reset", 1'b1, 1'b0, 32'h0000_3000));
    vecs.push_back(plain("normal", 32'h0000_3004, 5'd8, 32'h0000_1234, 2'd2, 2'd1));
    vecs.push_back(plain("tnew0", 32'h0000_3008, 5'd4, 32'h0000_0010, 2'd0, 2'd0));
    vecs.push_back(plain("tnew1", 32'h0000_300C, 5'd5, 32'h0000_0020, 2'd1, 2'd0));
    vecs.push_back(plain("tnew3", 32'h0000_3010, 5'd6, 32'h0000_0030, 2'd3, 2'd2));
    vecs.push_back(exc_vec("ov_arith", 32'h0000_3014, 5'd9, 5'd0, 1'b1, 2'b01, 5'd0, 5'd12));
    vecs.push_back(exc_vec("ov_store", 32'h0000_3018, 5'd9, 5'd0, 1'b1, 2'b11, 5'd0, 5'd5));
    vecs.push_back(exc_vec("ov_ignore", 32'h0000_301C, 5'd9, 5'd0, 1'b1, 2'b00, 5'd9, 5'd0));
    vecs.push_back(exc_vec("ov_load", 32'h0000_3020, 5'd9, 5'd0, 1'b1, 2'b10, 5'd0, 5'd4));
    vecs.push_back(exc_vec("exc_prio", 32'h0000_3024, 5'd9, 5'd10, 1'b1, 2'b01, 5'd0, 5'd10));
    vecs.push_back(exc_vec("kind_no_ov", 32'h0000_3028, 5'd9, 5'd0, 1'b0, 2'b01, 5'd9, 5'd0));
    vecs.push_back(exc_vec("exc_only", 32'h0000_302C, 5'd31, 5'd4, 1'b0, 2'b00, 5'd0, 5'd4));
    vecs.push_back(bubble("flush", 1'b0, 1'b1, 32'h0000_4180));
    v = plain("after_flush", 32'h0000_4180, 5'd3, 32'h0000_0044, 2'd2, 2'd1);
    v.bd = 1'b1;  v.x_bd = 1'b1;
    vecs.push_back(v);
    vecs.push_back(bubble("req_and_reset", 1'b1, 1'b1, 32'h0000_3000));
    vecs.push_back(plain("resume1", 32'h0000_3000, 5'd2, 32'hFFFF_FFFF, 2'd1, 2'd0));
    vecs.push_back(bubble("reset_mid", 1'b1, 1'b0, 32'h0000_3000));
    vecs.push_back(plain("resume2", 32'h0000_3004, 5'd7, 32'h8000_0000, 2'd2, 2'd1));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check_all(vecs[i]);
    end

    // Outputs must not follow inputs between edges.
    @(negedge clk);
    drive(exc_vec("comb", 32'h0000_5000, 5'd1, 5'd0, 1'b1, 2'b01, 5'd0, 5'd12));
    Req = 1'b1;
    #1;
    check("comb.pc",  M_PC, 32'h0000_3004);
    check("comb.a3",  {27'd0, M_A3}, 32'd7);
    check("comb.exc", {27'd0, M_ExcCode}, 32'd0);

    // Back-to-back stream of directed captures, checked through the scoreboard.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pc_s = 32'h0000_3100 + 32'(i * 4);
      a3_s = 5'(i + 10);
      tn_s = 2'(i % 4);
      v = plain("b2b", pc_s, a3_s, 32'(i), tn_s, 2'd0);
      if (i == 3) begin
        v.ov = 1'b1;  v.ovk = 2'b10;
      end
      drive(v);
      // Hand-derived: tnew 0,1,2,3,0,1 -> 0,0,1,2,0,0; i==3 becomes AdEL.
      case (i)
        0: exp_q.push_back({pc_s, a3_s, 2'd0, 5'd0});
        1: exp_q.push_back({pc_s, a3_s, 2'd0, 5'd0});
        2: exp_q.push_back({pc_s, a3_s, 2'd1, 5'd0});
        3: exp_q.push_back({pc_s, 5'd0, 2'd2, 5'd4});
        4: exp_q.push_back({pc_s, a3_s, 2'd0, 5'd0});
        default: exp_q.push_back({pc_s, a3_s, 2'd0, 5'd0});
      endcase
      @(posedge clk);
      #1;
      got = {M_PC, M_A3, M_Tnew, M_ExcCode};
      check($sformatf("b2b[%0d]", i), 32'(got[11:0]) ^ M_PC, 32'(exp_q[0][11:0]) ^ exp_q[0][43:12]);
      check($sformatf("b2b_pc[%0d]", i), M_PC, exp_q[0][43:12]);
      void'(exp_q.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
